// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types (address, data, strobe, response code) and an address-alignment helper.
// Latency: not applicable (types and pure functions only).
// Backpressure: not applicable.
package axi4l_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // Clears the byte-lane bits so the bus only sees word addresses when enabled.
  function automatic addr_t align_word(input addr_t a, input bit en);
    return en ? {a[31:2], 2'b00} : a;
  endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle (AW, W, B, AR, R) with clock and active-low reset carried alongside.
// Latency: none, wires only.
// Backpressure: standard per-channel valid/ready.
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

endinterface

// File: rtl/axi4l_master.sv
// Single-outstanding AXI4-Lite initiator bridging a req/gnt core port; AXI4L_MASTER_FAST_RESP_EN drops the RESP state.
// Latency: grant->rvalid_o is 3 cycles with a ready responder (2 with AXI4L_MASTER_FAST_RESP_EN).
// Backpressure: gnt_o only in IDLE; AW/W/AR valids held with stable payload until each handshake.
module axi4l_master
  import axi4l_pkg::*;
#(
  parameter int unsigned ALIGN_ADDR = 1
) (
  axi4l_if.master     axi,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

`ifdef AXI4L_MASTER_FAST_RESP_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4,
    RESP  = 3'd5
  } state_e;
`endif

  state_e state_q, state_d;
  addr_t  addr_q, addr_d;
  strb_t  be_q, be_d;
  data_t  wdata_q, wdata_d;
  logic   aw_pend_q, aw_pend_d;
  logic   w_pend_q, w_pend_d;
`ifndef AXI4L_MASTER_FAST_RESP_EN
  data_t  rdata_q, rdata_d;
  logic   err_q, err_d;
`endif

  logic awvalid, wvalid, arvalid, bready, rready;

  // Payload is taken from the captured request, so it cannot move while a valid is up.
  assign axi.awvalid = awvalid;
  assign axi.awaddr  = addr_q;
  assign axi.wvalid  = wvalid;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.arvalid = arvalid;
  assign axi.araddr  = addr_q;
  assign axi.bready  = bready;
  assign axi.rready  = rready;

  // Next-state, request capture and channel handshakes; AW and W retire independently.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    gnt_o     = 1'b0;
    awvalid   = (state_q == WADDR) && aw_pend_q;
    wvalid    = (state_q == WADDR) && w_pend_q;
    arvalid   = (state_q == RADDR);
    bready    = (state_q == WRESP);
    rready    = (state_q == RRESP);
`ifdef AXI4L_MASTER_FAST_RESP_EN
    rvalid_o  = 1'b0;
    rdata_o   = '0;
    err_o     = 1'b0;
`else
    rdata_d   = rdata_q;
    err_d     = err_q;
    rvalid_o  = (state_q == RESP);
    rdata_o   = rdata_q;
    err_o     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_i) begin
          gnt_o   = 1'b1;
          addr_d  = align_word(addr_i, ALIGN_ADDR != 0);
          be_d    = be_i;
          wdata_d = wdata_i;
          if (we_i) begin
            state_d   = WADDR;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d = RADDR;
          end
        end
      end
      WADDR: begin
        if (awvalid && axi.awready) aw_pend_d = 1'b0;
        if (wvalid && axi.wready)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = WRESP;
      end
      WRESP: begin
        if (axi.bvalid) begin
`ifdef AXI4L_MASTER_FAST_RESP_EN
          rvalid_o = 1'b1;
          err_o    = (axi.bresp != RESP_OKAY);
          state_d  = IDLE;
`else
          rdata_d = '0;
          err_d   = (axi.bresp != RESP_OKAY);
          state_d = RESP;
`endif
        end
      end
      RADDR: begin
        if (axi.arready) state_d = RRESP;
      end
      RRESP: begin
        if (axi.rvalid) begin
`ifdef AXI4L_MASTER_FAST_RESP_EN
          rvalid_o = 1'b1;
          rdata_o  = axi.rdata;
          err_o    = (axi.rresp != RESP_OKAY);
          state_d  = IDLE;
`else
          rdata_d = axi.rdata;
          err_d   = (axi.rresp != RESP_OKAY);
          state_d = RESP;
`endif
        end
      end
`ifndef AXI4L_MASTER_FAST_RESP_EN
      RESP: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers; reset abandons any transaction in flight.
  always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
    if (!axi.aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
`ifndef AXI4L_MASTER_FAST_RESP_EN
      rdata_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
`ifndef AXI4L_MASTER_FAST_RESP_EN
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: doc/axi4l_master.md
AXI4L_MASTER -- requirements
Module: axi4l_master

Interface
REQ-001 SHALL have parameter ALIGN_ADDR, default 1, meaning: when 1, awaddr/araddr[1:0] are forced to 2'b00.
REQ-002 SHALL have port axi.aclk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port axi.aresetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port axi  axi4l_if.master  -  AXI4-Lite initiator (AW, W, B, AR, R channels).
REQ-005 SHALL have port req_i  input  1  core request.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port be_i  input  4  byte enables.
REQ-008 SHALL have port addr_i  input  32  byte address.
REQ-009 SHALL have port wdata_i  input  32  write data.
REQ-010 SHALL have port gnt_o  output  1  request accepted; addr/we/be/wdata captured.
REQ-011 SHALL have port rvalid_o  output  1  one-cycle response pulse.
REQ-012 SHALL have port rdata_o  output  32  read data, valid with rvalid_o.
REQ-013 SHALL have port err_o  output  1  response was not OKAY, valid with rvalid_o.

Function
REQ-014 SHALL implement FSM states IDLE, WADDR (AW/W pending), WRESP, RADDR, RRESP, RESP; one transaction outstanding at most.
REQ-015 SHALL assert gnt_o combinationally iff state==IDLE && req_i, and capture addr/we/be/wdata in that cycle.
REQ-016 On grant with we_i=1: SHALL go to WADDR and assert awvalid and wvalid from the next cycle; wstrb=be, wdata=captured data.
REQ-017 SHALL deassert awvalid on AW handshake and wvalid on W handshake, independently; SHALL leave WADDR only when both are done, in either order or in the same cycle.
REQ-018 SHALL hold awaddr/wdata/wstrb/araddr stable while the corresponding valid is high.
REQ-019 In WRESP: bready=1; on B handshake, err = (bresp != OKAY), rdata_o=0.
REQ-020 On grant with we_i=0: RADDR asserts arvalid until the AR handshake; RRESP asserts rready=1; on R handshake capture rdata and err = (rresp != OKAY).
REQ-021 After the B/R handshake: SHALL go to RESP, pulse rvalid_o for exactly one cycle, then return to IDLE (gnt_o not possible in RESP).
REQ-022 Latency with an always-ready responder: grant at cycle 0, AW/W or AR handshake at cycle 1, B/R handshake at cycle 2, rvalid_o at cycle 3.
REQ-023 bready/rready SHALL be 0 outside WRESP/RRESP; awvalid/wvalid/arvalid SHALL never assert in IDLE.

Reset
REQ-024 On aresetn low, asynchronously: state=IDLE; awvalid, wvalid, arvalid, bready, rready, rvalid_o, err_o = 0; rdata_o = 0.
REQ-025 Reset mid-transaction SHALL abandon it with no rvalid_o pulse; after release the first cycle SHALL be IDLE.

Configuration
REQ-026 Macro AXI4L_MASTER_FAST_RESP_EN: defined -> RESP state is removed and rvalid_o/rdata_o/err_o are driven combinationally in the B/R handshake cycle (latency 2); undefined -> registered as in REQ-021 (latency 3).

Structure
REQ-027 resp_t (OKAY/SLVERR...), addr_t and strb_t SHALL come from axi4l_pkg; the FSM state enum SHALL be local to the module.
REQ-028 No sub-module is required; single module.

Verification
REQ-029 Write 0x1234_5678, be=4'hF, addr 0x0000_0004, responder always ready -> AW/W at cycle 1, bready at cycle 2, rvalid_o=1, err_o=0 at cycle 3.
REQ-030 Read addr 0x0000_0000, rdata=0xCAFE_F00D, rresp=OKAY -> rvalid_o one cycle, rdata_o=0xCAFE_F00D, err_o=0.
REQ-031 Responder delays wready 3 cycles after awready -> awvalid drops after 1 cycle, wvalid held 4 cycles with stable wdata, single rvalid_o.
REQ-032 Read of 0x0000_0800 returning rresp=SLVERR -> rvalid_o=1, err_o=1; a write with bresp=SLVERR -> err_o=1.
REQ-033 req_i held high back-to-back -> gnt_o only in IDLE, no second AW/AR before the previous rvalid_o pulse.
REQ-034 aresetn low while arvalid is pending -> arvalid=0 immediately, no rvalid_o; after release a new read completes normally.
